// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use scoreboard with stall generation, jump-driven
// flush sequencing and a sticky timeout flag for stalls that never resolve.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid_i,
    input  logic [4:0]  reg1_rd_addr_i,
    input  logic [4:0]  reg2_rd_addr_i,
    input  logic [4:0]  reg_wr_addr_i,
    input  logic        id_is_load_i,
    input  logic        ld_done_i,
    input  logic [4:0]  ld_done_addr_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic        stall_o,
    output logic        flush_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o,
    output logic [31:0] pending_o,
    output logic        timeout_o
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    localparam logic [3:0] STALL_MAX = 4'hF;

    logic [0:0]  state_q;
    logic [0:0]  state_d;
    logic [31:0] pending_q;
    logic [31:0] pending_d;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;
    logic [3:0]  stall_cnt_q;
    logic [3:0]  stall_cnt_d;
    logic        timeout_q;
    logic        hit1;
    logic        hit2;
    logic        issue;

    // A read hits only if the load is still outstanding after this cycle's
    // write-back; a load completing now is visible through the regfile bypass.
    function automatic logic hit(
        input logic [4:0]  addr,
        input logic [31:0] pend,
        input logic        done,
        input logic [4:0]  done_addr
    );
        hit = (addr != 5'd0) && pend[addr] && !(done && (done_addr == addr));
    endfunction

    assign hit1 = hit(reg1_rd_addr_i, pending_q, ld_done_i, ld_done_addr_i);
    assign hit2 = hit(reg2_rd_addr_i, pending_q, ld_done_i, ld_done_addr_i);

    assign flush_o     = jump_i | (state_q == FLUSH);
    assign stall_o     = id_valid_i & (hit1 | hit2) & ~flush_o;
    assign issue       = id_valid_i & ~stall_o & ~flush_o;
    assign jump_o      = jump_i;
    assign jump_addr_o = jump_i ? jump_addr_i : 32'd0;
    assign pending_o   = pending_q;
    assign timeout_o   = timeout_q;

    always_comb begin
        set_vec = 32'd0;
        if (issue && id_is_load_i && (reg_wr_addr_i != 5'd0)) begin
            set_vec = 32'd1 << reg_wr_addr_i;
        end
    end

    always_comb begin
        clr_vec = 32'd0;
        if (ld_done_i) begin
            clr_vec = 32'd1 << ld_done_addr_i;
        end
    end

    // Set is applied after clear so a same-cycle issue and completion leaves the bit set.
    assign pending_d = ((pending_q & ~clr_vec) | set_vec) & 32'hFFFF_FFFE;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = jump_i ? FLUSH : IDLE;
            FLUSH:   state_d = jump_i ? FLUSH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_cnt_d = 4'd0;
        if (stall_o) begin
            stall_cnt_d = (stall_cnt_q == STALL_MAX) ? STALL_MAX : stall_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= 32'd0;
            stall_cnt_q <= 4'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
            if (stall_cnt_d == STALL_MAX) begin
                timeout_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl: inputs change on the falling edge,
// combinational outputs are checked 1 time unit later, registered ones after the next edge.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid_i;
    logic [4:0]  reg1_rd_addr_i;
    logic [4:0]  reg2_rd_addr_i;
    logic [4:0]  reg_wr_addr_i;
    logic        id_is_load_i;
    logic        ld_done_i;
    logic [4:0]  ld_done_addr_i;
    logic        jump_i;
    logic [31:0] jump_addr_i;
    logic        stall_o;
    logic        flush_o;
    logic        jump_o;
    logic [31:0] jump_addr_o;
    logic [31:0] pending_o;
    logic        timeout_o;

    int total;
    int bad;

    hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid_i),
        .reg1_rd_addr_i (reg1_rd_addr_i),
        .reg2_rd_addr_i (reg2_rd_addr_i),
        .reg_wr_addr_i  (reg_wr_addr_i),
        .id_is_load_i   (id_is_load_i),
        .ld_done_i      (ld_done_i),
        .ld_done_addr_i (ld_done_addr_i),
        .jump_i         (jump_i),
        .jump_addr_i    (jump_addr_i),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .jump_o         (jump_o),
        .jump_addr_o    (jump_addr_o),
        .pending_o      (pending_o),
        .timeout_o      (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        id_valid_i     = 1'b0;
        reg1_rd_addr_i = 5'd0;
        reg2_rd_addr_i = 5'd0;
        reg_wr_addr_i  = 5'd0;
        id_is_load_i   = 1'b0;
        ld_done_i      = 1'b0;
        ld_done_addr_i = 5'd0;
        jump_i         = 1'b0;
        jump_addr_i    = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        jump_i = 1'b1;
        jump_addr_i = 32'h0000_0055;
        id_valid_i = 1'b1;
        #1;
        total++; if (pending_o !== 32'd0) begin bad++; $display("FAIL rst_pending: got %h want %h", pending_o, 32'd0); end
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", stall_o); end
        total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL rst_flush_jump: got %b want 1", flush_o); end
        total++; if (jump_o !== 1'b1) begin bad++; $display("FAIL rst_jump: got %b want 1", jump_o); end
        total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", timeout_o); end
        @(negedge clk);
        jump_i = 1'b0;
        #1;
        total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL rst_flush_nojump: got %b want 0", flush_o); end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL rst_release_flush: got %b want 0", flush_o); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        id_valid_i = 1'b1; id_is_load_i = 1'b1; reg_wr_addr_i = 5'd5;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL lu_issue_stall: got %b want 0", stall_o); end
        @(negedge clk);
        total++; if (pending_o !== 32'h0000_0020) begin bad++; $display("FAIL lu_pending_set: got %h want %h", pending_o, 32'h20); end
        id_is_load_i = 1'b0; reg_wr_addr_i = 5'd6; reg1_rd_addr_i = 5'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL lu_stall_%0d: got %b want 1", i, stall_o); end
            @(negedge clk);
        end
        total++; if (pending_o !== 32'h0000_0020) begin bad++; $display("FAIL lu_pending_held: got %h want %h", pending_o, 32'h20); end
        ld_done_i = 1'b1; ld_done_addr_i = 5'd5;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL lu_bypass_stall: got %b want 0", stall_o); end
        @(negedge clk);
        idle_inputs();
        total++; if (pending_o !== 32'd0) begin bad++; $display("FAIL lu_pending_clr: got %h want 0", pending_o); end
    endtask

    task automatic test_x0_load();
        @(negedge clk);
        id_valid_i = 1'b1; id_is_load_i = 1'b1; reg_wr_addr_i = 5'd0;
        @(negedge clk);
        total++; if (pending_o !== 32'd0) begin bad++; $display("FAIL x0_pending: got %h want 0", pending_o); end
        id_is_load_i = 1'b0; reg1_rd_addr_i = 5'd0; reg2_rd_addr_i = 5'd0;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL x0_stall: got %b want 0", stall_o); end
        @(negedge clk);
        idle_inputs();
        total++; if (pending_o !== 32'd0) begin bad++; $display("FAIL x0_pending_after: got %h want 0", pending_o); end
    endtask

    task automatic test_jump();
        @(negedge clk);
        jump_i = 1'b0; jump_addr_i = 32'hDEAD_BEEF;
        #1;
        total++; if (jump_addr_o !== 32'd0) begin bad++; $display("FAIL jmp_addr_masked: got %h want 0", jump_addr_o); end
        @(negedge clk);
        jump_i = 1'b1; jump_addr_i = 32'h0000_0100;
        #1;
        total++; if (jump_o !== 1'b1) begin bad++; $display("FAIL jmp_strobe: got %b want 1", jump_o); end
        total++; if (jump_addr_o !== 32'h0000_0100) begin bad++; $display("FAIL jmp_addr: got %h want %h", jump_addr_o, 32'h100); end
        total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL jmp_flush_c0: got %b want 1", flush_o); end
        @(negedge clk);
        jump_i = 1'b0; jump_addr_i = 32'd0;
        #1;
        total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL jmp_flush_c1: got %b want 1", flush_o); end
        total++; if (jump_o !== 1'b0) begin bad++; $display("FAIL jmp_strobe_off: got %b want 0", jump_o); end
        @(negedge clk);
        #1;
        total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL jmp_flush_c2: got %b want 0", flush_o); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        jump_i = 1'b1; jump_addr_i = 32'h0000_0200;
        #1;
        total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL b2b_flush_c0: got %b want 1", flush_o); end
        @(negedge clk);
        jump_addr_i = 32'h0000_0300;
        #1;
        total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL b2b_flush_c1: got %b want 1", flush_o); end
        total++; if (jump_addr_o !== 32'h0000_0300) begin bad++; $display("FAIL b2b_addr: got %h want %h", jump_addr_o, 32'h300); end
        @(negedge clk);
        jump_i = 1'b0; jump_addr_i = 32'd0;
        #1;
        total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL b2b_flush_c2: got %b want 1", flush_o); end
        @(negedge clk);
        #1;
        total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL b2b_flush_c3: got %b want 0", flush_o); end
    endtask

    task automatic test_flush_over_stall();
        @(negedge clk);
        id_valid_i = 1'b1; id_is_load_i = 1'b1; reg_wr_addr_i = 5'd7;
        @(negedge clk);
        reg_wr_addr_i = 5'd9; reg2_rd_addr_i = 5'd7; jump_i = 1'b1; jump_addr_i = 32'h0000_0400;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL fos_stall: got %b want 0", stall_o); end
        total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL fos_flush: got %b want 1", flush_o); end
        @(negedge clk);
        total++; if (pending_o !== 32'h0000_0080) begin bad++; $display("FAIL fos_pending: got %h want %h", pending_o, 32'h80); end
        jump_i = 1'b0; jump_addr_i = 32'd0;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL fos_stall_c1: got %b want 0", stall_o); end
        @(negedge clk);
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL fos_stall_resume: got %b want 1", stall_o); end
        @(negedge clk);
        idle_inputs();
        ld_done_i = 1'b1; ld_done_addr_i = 5'd7;
        @(negedge clk);
        idle_inputs();
        total++; if (pending_o !== 32'd0) begin bad++; $display("FAIL fos_pending_clr: got %h want 0", pending_o); end
    endtask

    task automatic test_collision();
        @(negedge clk);
        id_valid_i = 1'b1; id_is_load_i = 1'b1; reg_wr_addr_i = 5'd3;
        ld_done_i = 1'b1; ld_done_addr_i = 5'd3;
        @(negedge clk);
        idle_inputs();
        total++; if (pending_o !== 32'h0000_0008) begin bad++; $display("FAIL coll_set_wins: got %h want %h", pending_o, 32'h8); end
        ld_done_i = 1'b1; ld_done_addr_i = 5'd3;
        @(negedge clk);
        idle_inputs();
        total++; if (pending_o !== 32'd0) begin bad++; $display("FAIL coll_clear: got %h want 0", pending_o); end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        id_valid_i = 1'b1; id_is_load_i = 1'b1; reg_wr_addr_i = 5'd4;
        @(negedge clk);
        id_is_load_i = 1'b0; reg_wr_addr_i = 5'd1; reg1_rd_addr_i = 5'd4;
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL to_stall: got %b want 1", stall_o); end
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            #1;
            if (i == 14) begin
                total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", timeout_o); end
            end
            if (i == 15) begin
                total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL to_set: got %b want 1", timeout_o); end
            end
        end
        ld_done_i = 1'b1; ld_done_addr_i = 5'd4;
        @(negedge clk);
        idle_inputs();
        #1;
        total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", timeout_o); end
        total++; if (pending_o !== 32'd0) begin bad++; $display("FAIL to_pending_clr: got %h want 0", pending_o); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL to_rst_clear: got %b want 0", timeout_o); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        id_valid_i = 1'b1; id_is_load_i = 1'b1; reg_wr_addr_i = 5'd12;
        @(negedge clk);
        id_is_load_i = 1'b0; reg_wr_addr_i = 5'd1; reg1_rd_addr_i = 5'd12;
        #1;
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL ab_stall_pre: got %b want 1", stall_o); end
        rst = 1'b1;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL ab_stall_rst: got %b want 0", stall_o); end
        total++; if (pending_o !== 32'd0) begin bad++; $display("FAIL ab_pending_rst: got %h want 0", pending_o); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL ab_stall_post: got %b want 0", stall_o); end
        @(negedge clk);
        idle_inputs();
        jump_i = 1'b1; jump_addr_i = 32'h0000_0500;
        @(negedge clk);
        jump_i = 1'b0; jump_addr_i = 32'd0;
        #1;
        total++; if (flush_o !== 1'b1) begin bad++; $display("FAIL ab_flush_pre: got %b want 1", flush_o); end
        rst = 1'b1;
        #1;
        total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL ab_flush_rst: got %b want 0", flush_o); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        total++; if (flush_o !== 1'b0) begin bad++; $display("FAIL ab_flush_post: got %b want 0", flush_o); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_x0_load();
        test_jump();
        test_back_to_back();
        test_flush_over_stall();
        test_collision();
        do_reset();
        test_timeout();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
